// File: rtl/rs_pkg.sv
// Shared definitions for the RS decoder over GF(2^5), primitive polynomial x^5+x^2+1.
package rs_pkg;

   localparam int GF_M = 5;
   localparam int RS_N = 31;

   // Low terms of the primitive polynomial (x^5 = x^2 + 1).
   localparam logic [GF_M-1:0] PRIM_POLY = 5'b00101;

   // alpha^j for j = 0..30, bit k = coefficient of x^k.
   localparam logic [GF_M-1:0] ALPHA_POW [0:RS_N-1] = '{
      5'd1,  5'd2,  5'd4,  5'd8,  5'd16, 5'd5,  5'd10, 5'd20,
      5'd13, 5'd26, 5'd17, 5'd7,  5'd14, 5'd28, 5'd29, 5'd31,
      5'd27, 5'd19, 5'd3,  5'd6,  5'd12, 5'd24, 5'd21, 5'd15,
      5'd30, 5'd25, 5'd23, 5'd11, 5'd22, 5'd9,  5'd18
   };

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } synd_state_e;

   // Width of the packed syndrome bus for a given syndrome count.
   function automatic int synd_width(input int nsyn);
      return GF_M * nsyn;
   endfunction

endpackage

// File: rtl/rs_syndrome_calc_if.sv
// Symbol input and syndrome result bundle of the syndrome calculator.
interface rs_syndrome_calc_if #(
   parameter int NSYN = 4
);

   logic                              in_valid;
   logic                              in_sop;
   logic [rs_pkg::GF_M-1:0]           in_sym;
   logic                              busy;
   logic                              synd_valid;
   logic [rs_pkg::GF_M*NSYN-1:0]      synd;
   logic                              synd_nonzero;
   logic                              sop_err;

   modport master (
      output in_valid, in_sop, in_sym,
      input  busy, synd_valid, synd, synd_nonzero, sop_err
   );

   modport slave (
      input  in_valid, in_sop, in_sym,
      output busy, synd_valid, synd, synd_nonzero, sop_err
   );

endinterface

// File: rtl/gfadder.sv
// GF(2^5) adder: coefficient-wise XOR.
module gfadder (
   input  logic [0:4] a,
   input  logic [0:4] b,
   output logic [0:4] s
);

   assign s = a ^ b;

endmodule

// File: rtl/lcpmult.sv
// Combinational GF(2^5) multiplier; index k of every bus is the coefficient of x^k.
module lcpmult
   import rs_pkg::*;
(
   input  logic [0:4] a,
   input  logic [0:4] b,
   output logic [0:4] p
);

   logic [4:0] a_v;
   logic [4:0] prod;

   assign a_v = {a[4], a[3], a[2], a[1], a[0]};

   // Shift-and-add from the top coefficient of b, reducing by x^5 = x^2 + 1 each step.
   always_comb begin
      prod = '0;
      for (int i = 4; i >= 0; i--) begin
         prod = {prod[3:0], 1'b0} ^ (prod[4] ? PRIM_POLY : 5'b00000);
         if (b[i]) begin
            prod = prod ^ a_v;
         end
      end
   end

   assign p = {prod[0], prod[1], prod[2], prod[3], prod[4]};

endmodule

// File: rtl/rs_syndrome_cell.sv
// One Horner accumulator A <= A*alpha^POW + sym; acc exposes the value being loaded
// this edge so the top level can capture a finished syndrome without a cycle of delay.
module rs_syndrome_cell
   import rs_pkg::*;
#(
   parameter int POW = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [GF_M-1:0]  sym,
   output logic [GF_M-1:0]  acc
);

   localparam logic [GF_M-1:0] ALPHA_K = ALPHA_POW[POW];

   logic [GF_M-1:0] acc_q;
   logic [GF_M-1:0] acc_d;
   logic [0:4]      mul_a;
   logic [0:4]      mul_b;
   logic [0:4]      mul_p;
   logic [0:4]      add_b;
   logic [0:4]      add_s;

   assign mul_a = {acc_q[0], acc_q[1], acc_q[2], acc_q[3], acc_q[4]};
   assign mul_b = {ALPHA_K[0], ALPHA_K[1], ALPHA_K[2], ALPHA_K[3], ALPHA_K[4]};
   assign add_b = {sym[0], sym[1], sym[2], sym[3], sym[4]};

   lcpmult u_mult (
      .a (mul_a),
      .b (mul_b),
      .p (mul_p)
   );

   gfadder u_add (
      .a (mul_p),
      .b (add_b),
      .s (add_s)
   );

   // Next accumulator: load starts a new codeword, en advances Horner, otherwise hold.
   always_comb begin
      acc_d = acc_q;
      if (load) begin
         acc_d = sym;
      end else if (en) begin
         acc_d = {add_s[4], add_s[3], add_s[2], add_s[1], add_s[0]};
      end
   end

   // Accumulator register.
   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_d;

endmodule

// File: rtl/rs_syndrome_calc.sv
// Syndrome calculator: NSYN Horner cells, symbol counter, busy FSM and result registers.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  ST_IDLE | no codeword open; only an sop symbol is accepted
//  ST_RUN  | codeword open, cnt symbols taken; completes when cnt hits N
module rs_syndrome_calc
   import rs_pkg::*;
#(
   parameter int N    = 31,
   parameter int NSYN = 4
) (
   input  logic               clock,
   input  logic               reset,
   rs_syndrome_calc_if.slave  sif
);

   localparam int         SW       = synd_width(NSYN);
   localparam logic [4:0] CNT_LAST = 5'(N);

   synd_state_e   state_q, state_d;
   logic [4:0]    cnt_q, cnt_d;
   logic [SW-1:0] synd_q, synd_d;
   logic          nz_q, nz_d;
   logic          synd_valid_q, synd_valid_d;
   logic          sop_err_q, sop_err_d;
   logic          sym_en;
   logic          sym_load;
   logic [SW-1:0] acc_nxt;

   for (genvar g = 0; g < NSYN; g++) begin : g_cell
      rs_syndrome_cell #(.POW(g + 1)) u_cell (
         .clock (clock),
         .reset (reset),
         .en    (sym_en),
         .load  (sym_load),
         .sym   (sif.in_sym),
         .acc   (acc_nxt[g*GF_M +: GF_M])
      );
   end

   // Next state, counter, cell enables, completion and protocol-error detection.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sym_en       = 1'b0;
      sym_load     = 1'b0;
      sop_err_d    = 1'b0;
      synd_valid_d = 1'b0;
      if (sif.in_valid) begin
         if (sif.in_sop) begin
            sym_en    = 1'b1;
            sym_load  = 1'b1;
            cnt_d     = 5'd1;
            sop_err_d = (state_q == ST_RUN);
            state_d   = ST_RUN;
         end else if (state_q == ST_RUN) begin
            sym_en = 1'b1;
            cnt_d  = cnt_q + 5'd1;
         end else begin
            sop_err_d = 1'b1;
         end
         if (sym_en && (cnt_d == CNT_LAST)) begin
            synd_valid_d = 1'b1;
            state_d      = ST_IDLE;
         end
      end
      synd_d = synd_valid_d ? acc_nxt : synd_q;
      nz_d   = synd_valid_d ? (|acc_nxt) : nz_q;
   end

   // Control state and symbol counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Result registers: syndromes held until the next completion, pulses for one cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         synd_q       <= '0;
         nz_q         <= 1'b0;
         synd_valid_q <= 1'b0;
         sop_err_q    <= 1'b0;
      end else begin
         synd_q       <= synd_d;
         nz_q         <= nz_d;
         synd_valid_q <= synd_valid_d;
         sop_err_q    <= sop_err_d;
      end
   end

   assign sif.busy         = (state_q == ST_RUN);
   assign sif.synd         = synd_q;
   assign sif.synd_nonzero = nz_q;
   assign sif.synd_valid   = synd_valid_q;
   assign sif.sop_err      = sop_err_q;

endmodule
